// File: rtl/bbc_micro_pkg.sv
// Shared definitions for the BBC Micro 1MHz bus slice.
// Holds the FSM state type, decode ranges, select bit indices and phases.
package bbc_micro_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RISE = 2'd1,
      ACTIVE    = 2'd2,
      DONE      = 2'd3
   } state_t;

   localparam logic [1:0] PHI1 = 2'b01;
   localparam logic [1:0] PHI2 = 2'b10;

   localparam logic [15:0] FRED_BASE = 16'hFC00;
   localparam logic [15:0] FRED_MASK = 16'hFF00;
   localparam logic [15:0] JIM_BASE  = 16'hFD00;
   localparam logic [15:0] JIM_MASK  = 16'hFF00;
   localparam logic [15:0] SVIA_BASE = 16'hFE40;
   localparam logic [15:0] SVIA_MASK = 16'hFFE0;
   localparam logic [15:0] UVIA_BASE = 16'hFE60;
   localparam logic [15:0] UVIA_MASK = 16'hFFE0;

   localparam int SEL_FRED = 0;
   localparam int SEL_JIM  = 1;
   localparam int SEL_SVIA = 2;
   localparam int SEL_UVIA = 3;

   function automatic logic in_range(
      input logic [15:0] a,
      input logic [15:0] base,
      input logic [15:0] mask
   );
      return (a & mask) == base;
   endfunction

endpackage

// File: rtl/bbc_micro_one_mhz_bus_if.sv
// CPU-side bus bundle of the 1MHz bus bridge.
// master = CPU (drives address/control), slave = bridge (returns read data).
interface bbc_micro_one_mhz_bus_if;

   logic        cpu_valid;
   logic [15:0] cpu_address;
   logic        cpu_read_not_write;
   logic [7:0]  cpu_write_data;
   logic [7:0]  cpu_read_data;
   logic        cpu_read_data_valid;

   modport master (
      output cpu_valid,
      output cpu_address,
      output cpu_read_not_write,
      output cpu_write_data,
      input  cpu_read_data,
      input  cpu_read_data_valid
   );

   modport slave (
      input  cpu_valid,
      input  cpu_address,
      input  cpu_read_not_write,
      input  cpu_write_data,
      output cpu_read_data,
      output cpu_read_data_valid
   );

endinterface

// File: rtl/bbc_micro_one_mhz_decode.sv
// Combinational 1MHz bus address decode.
// Ports: address, valid in; one-hot select and hit out.
module bbc_micro_one_mhz_decode
   import bbc_micro_pkg::*;
(
   input  logic [15:0] address,
   input  logic        valid,
   output logic [3:0]  select,
   output logic        hit
);

   logic [3:0] match;

   always_comb begin
      match           = '0;
      match[SEL_FRED] = in_range(address, FRED_BASE, FRED_MASK);
      match[SEL_JIM]  = in_range(address, JIM_BASE, JIM_MASK);
      match[SEL_SVIA] = in_range(address, SVIA_BASE, SVIA_MASK);
      match[SEL_UVIA] = in_range(address, UVIA_BASE, UVIA_MASK);
   end

   assign hit    = valid && $onehot(match);
   assign select = hit ? match : 4'b0000;

endmodule

// File: rtl/bbc_micro_one_mhz_bus.sv
// Bridge from the CPU bus to the 1MHz peripherals (FRED, JIM, VIAs).
// Ports: clk/reset_n, clock_control inputs, CPU bus, peripheral bus, count.
module bbc_micro_one_mhz_bus
   import bbc_micro_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          clk_enable,
   input  logic                          cc_enable_cpu,
   input  logic                          cc_enable_1MHz_rising,
   input  logic                          cc_enable_1MHz_falling,
   input  logic                          cc_reset_cpu,
   input  logic [1:0]                    cc_phi,
   bbc_micro_one_mhz_bus_if.slave        bus,
   input  logic [7:0]                    per_read_data,
   output logic                          cpu_1MHz_access,
   output logic [3:0]                    per_select,
   output logic [7:0]                    per_address,
   output logic                          per_read_not_write,
   output logic [7:0]                    per_write_data,
   output logic                          per_strobe,
   output logic [15:0]                   access_count
);

   state_t      state;
   state_t      nxt;
   logic [3:0]  dec_sel;
   logic        dec_hit;
   logic [3:0]  sel_q;
   logic [7:0]  addr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  rd_q;
   logic        rnw_q;
   logic [15:0] count_q;
   logic        start;
   logic        active;
   logic        fall_now;
   logic        latch;
   logic        capture;

   bbc_micro_one_mhz_decode u_decode (
      .address (bus.cpu_address),
      .valid   (bus.cpu_valid),
      .select  (dec_sel),
      .hit     (dec_hit)
   );

   assign start    = (state == IDLE) && (cc_phi == PHI1) && dec_hit;
   assign active   = (state == ACTIVE);
   assign fall_now = active && cc_enable_1MHz_falling;
   // a CPU reset aborts the cycle, so neither latch nor capture happens
   assign latch    = start && !cc_reset_cpu;
   assign capture  = fall_now && !cc_reset_cpu;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else if (clk_enable) begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      if (cc_reset_cpu) begin
         nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:      if (start) nxt = WAIT_RISE;
            WAIT_RISE: if (cc_enable_1MHz_rising) nxt = ACTIVE;
            ACTIVE:    if (cc_enable_1MHz_falling)
                          nxt = cc_enable_cpu ? IDLE : DONE;
            DONE:      if (cc_enable_cpu) nxt = IDLE;
            default:   nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      cpu_1MHz_access         = start || (state != IDLE);
      per_select              = active ? sel_q : 4'b0000;
      per_strobe              = active;
      per_address             = addr_q;
      per_read_not_write      = rnw_q;
      per_write_data          = wdata_q;
      access_count            = count_q;
      bus.cpu_read_data_valid = rnw_q && (fall_now || (state == DONE));
      bus.cpu_read_data       = fall_now ? per_read_data : rd_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q   <= 4'b0000;
         addr_q  <= 8'h00;
         wdata_q <= 8'h00;
         rnw_q   <= 1'b1;
         rd_q    <= 8'h00;
         count_q <= 16'h0000;
      end else if (clk_enable) begin
         if (latch) begin
            sel_q   <= dec_sel;
            addr_q  <= bus.cpu_address[7:0];
            wdata_q <= bus.cpu_write_data;
            rnw_q   <= bus.cpu_read_not_write;
         end
         if (capture) begin
            rd_q <= per_read_data;
            if (count_q != 16'hFFFF) begin
               count_q <= count_q + 16'd1;
            end
         end
      end
   end

endmodule

// File: doc/bbc_micro_one_mhz_bus.md
BBC_MICRO_ONE_MHZ_BUS -- requirements
Module: bbc_micro_one_mhz_bus

Interface
REQ-001 SHALL: clk  input  1  system clock, 4MHz minimum; reset is reset_n, asynchronous, active-low; the clock is clk.
REQ-002 SHALL: reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL: clk_enable  input  1  gates every state update.
REQ-004 SHALL: cc_enable_cpu, cc_enable_1MHz_rising, cc_enable_1MHz_falling, cc_reset_cpu  input  1 each  clock_control fields from the clocking block.
REQ-005 SHALL: cc_phi  input  2  clock_control phase; 01 = phi1, 10 = phi2.
REQ-006 SHALL: cpu_valid  input  1  CPU address/control valid; cpu_address  input  16; cpu_read_not_write  input  1; cpu_write_data  input  8.
REQ-007 SHALL: per_read_data  input  8  read data from the addressed 1MHz peripheral.
REQ-008 SHALL: cpu_1MHz_access  output  1  clock_status field back to the clocking block.
REQ-009 SHALL: cpu_read_data  output  8; cpu_read_data_valid  output  1.
REQ-010 SHALL: per_select  output  4  one-hot: [0] FRED FC00-FCFF, [1] JIM FD00-FDFF, [2] system VIA FE40-FE5F, [3] user VIA FE60-FE7F.
REQ-011 SHALL: per_address  output  8 (low address byte); per_read_not_write  output  1; per_write_data  output  8; per_strobe  output  1.
REQ-012 SHALL: access_count  output  16  completed 1MHz accesses, saturating.

Function
REQ-013 SHALL: hit = cpu_valid AND the cpu_address decode matches exactly one REQ-010 range; all other addresses miss.
REQ-014 SHALL: states IDLE, WAIT_RISE, ACTIVE, DONE.
REQ-015 SHALL: IDLE -> WAIT_RISE when cc_phi==01 and hit; latch the select, cpu_address[7:0], read_not_write and write_data.
REQ-016 SHALL: a hit in IDLE with cc_phi!=01 is ignored. Hits in any state other than IDLE are ignored.
REQ-017 SHALL: WAIT_RISE -> ACTIVE on cc_enable_1MHz_rising. Waiting is unbounded.
REQ-018 SHALL: in ACTIVE, per_select (latched one-hot) and per_strobe are high; otherwise both are 0. per_address, per_read_not_write and per_write_data hold their latched values from IDLE exit until the next latch.
REQ-019 SHALL: ACTIVE with cc_enable_1MHz_falling: capture per_read_data into the read register and increment access_count (saturate at FFFF). Then go to IDLE if cc_enable_cpu is high in the same cycle, else go to DONE.
REQ-020 SHALL: DONE -> IDLE on cc_enable_cpu.
REQ-021 SHALL: cpu_1MHz_access = (IDLE and cc_phi==01 and hit) or state in {WAIT_RISE, ACTIVE, DONE}; combinational, zero latency.
REQ-022 SHALL: cpu_read_data_valid = latched read and ((ACTIVE and cc_enable_1MHz_falling) or DONE).
REQ-023 SHALL: cpu_read_data = per_read_data when in ACTIVE with cc_enable_1MHz_falling, else the read register.
REQ-024 SHALL: cc_reset_cpu forces IDLE the next cycle from any state, dropping per_select/per_strobe. The read register and access_count are kept.
REQ-025 SHALL: with clk_enable low, no state, register or counter changes; combinational outputs still track their inputs.

Reset
REQ-026 SHALL: on reset_n low:
- state = IDLE;
- read register, latched address and latched write data = 00;
- latched read_not_write = 1;
- access_count = 0000;
- hence per_select = 0, per_strobe = 0, cpu_read_data_valid = 0, and cpu_1MHz_access = 0 unless REQ-021 hits.

Structure
REQ-027 SHALL: the state enum, the four address-range base/mask constants and the select bit indices live in the shared bbc_micro package.
REQ-028 SHALL: address decode is the combinational sub-module bbc_micro_one_mhz_decode (address, valid -> one-hot select, hit).

Verification
REQ-029 SHALL: read FE44 in phi1, per_read_data=5A -> cpu_1MHz_access high the same cycle; per_select=0100 from rising until falling; cpu_read_data=5A with valid at the CPU enable; access_count=1.
REQ-030 SHALL: write FC10 data 3C -> per_select=0001, per_address=10, per_read_not_write=0, per_write_data=3C during ACTIVE; cpu_read_data_valid stays 0.
REQ-031 SHALL: access to 8000 or FE00 -> cpu_1MHz_access=0, per_select never asserted, access_count unchanged.
REQ-032 SHALL: cc_enable_1MHz_falling coincident with cc_enable_cpu in ACTIVE on read FD00 -> cpu_read_data equals per_read_data that cycle, next state IDLE.
REQ-033 SHALL: cc_reset_cpu asserted in WAIT_RISE and, separately, in ACTIVE -> IDLE next cycle, no strobe after, count unchanged. A separate case: reset_n pulsed in ACTIVE -> all REQ-026 values.
REQ-034 SHALL: access_count preset to FFFF by 65535 accesses, then one more -> stays FFFF.
